ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter; the opposite direction of the existing PS/2 keyboard receiver in the top level.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) over the same USER_IO clock/data pair.
- Drives the pair open-drain through pull-low enables and reports completion and ACK/timeout status.
- While this block is busy, the receiver gates itself with oBUSY.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_line_filter.sv | 51 +++++
 rtl/ps2_host_tx.sv | 210 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmitter state encoding, frame geometry and
// common keyboard command/response bytes.
package ps2_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_INHIBIT  = 3'd1;
  localparam logic [2:0] ST_START    = 3'd2;
  localparam logic [2:0] ST_XMIT     = 3'd3;
  localparam logic [2:0] ST_ACK      = 3'd4;
  localparam logic [2:0] ST_WAITIDLE = 3'd5;

  localparam int unsigned FRAME_BITS = 11;

  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  // Bits shifted out after the start bit: {stop, odd parity, D7..D0}, D0 first.
  function automatic logic [9:0] tx_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pad conditioner: 2-FF synchronizer followed by a FILT_CYC-sample
// debounce; also emits a one-cycle strobe when the filtered line falls.
module ps2_line_filter #(
  parameter int unsigned FILT_CYC = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_i,
  output logic line_o,
  output logic fall_o
);

  localparam int unsigned CW = $clog2(FILT_CYC + 1);

  logic [1:0]    sync_q;
  logic          line_q, line_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = '0;
    line_d = line_q;
    fall_d = 1'b0;
    if (sync_q[1] != line_q) begin
      if (cnt_q == CW'(FILT_CYC - 1)) begin
        line_d = sync_q[1];
        fall_d = line_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
      line_q <= 1'b1;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], pad_i};
      line_q <= line_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign line_o = line_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain pull-low outputs.
// Define PS2TX_RETRY_EN to re-send after NACK/timeout up to RETRY_MAX times.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYC = 5000,
  parameter int unsigned START_CYC   = 50,
  parameter int unsigned TIMEOUT_CYC = 750000,
  parameter int unsigned FILT_CYC    = 8,
  parameter int unsigned RETRY_MAX   = 2
) (
  input  logic       CLK50M,
  input  logic       RESET,
  input  logic       iPS2CLK,
  input  logic       iPS2DAT,
  output logic       oPS2CLK_LO,
  output logic       oPS2DAT_LO,
  input  logic [7:0] iDATA,
  input  logic       iREQ,
  output logic       oREADY,
  output logic       oBUSY,
  output logic       oDONE,
  output logic       oERR
);

  localparam int unsigned CNT_MAX =
    (TIMEOUT_CYC > INHIBIT_CYC) ? ((TIMEOUT_CYC > START_CYC) ? TIMEOUT_CYC : START_CYC)
                                : ((INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC);
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  logic             clk_line, clk_fall, dat_line, unused_dat_fall;
  logic [2:0]       state_q, state_d;
  logic [9:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic             clk_lo_q, clk_lo_d, dat_lo_q, dat_lo_d;
  logic             nack_q, nack_d;
  logic             end_txn, end_err, done_c, err_c;

`ifdef PS2TX_RETRY_EN
  localparam int unsigned RW = $clog2(RETRY_MAX + 2);
  logic [9:0]    frame_q, frame_d;
  logic [RW-1:0] retry_q, retry_d;
`else
  logic unused_retry_max;
  assign unused_retry_max = ^RETRY_MAX;
`endif

  ps2_line_filter #(.FILT_CYC(FILT_CYC)) u_clk_filt (
    .clk_i (CLK50M),
    .rst_i (RESET),
    .pad_i (iPS2CLK),
    .line_o(clk_line),
    .fall_o(clk_fall)
  );

  ps2_line_filter #(.FILT_CYC(FILT_CYC)) u_dat_filt (
    .clk_i (CLK50M),
    .rst_i (RESET),
    .pad_i (iPS2DAT),
    .line_o(dat_line),
    .fall_o(unused_dat_fall)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    clk_lo_d = clk_lo_q;
    dat_lo_d = dat_lo_q;
    nack_d   = nack_q;
    end_txn  = 1'b0;
    end_err  = 1'b0;
    done_c   = 1'b0;
    err_c    = 1'b0;
`ifdef PS2TX_RETRY_EN
    frame_d  = frame_q;
    retry_d  = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (iREQ) begin
          shreg_d  = tx_frame(iDATA);
          state_d  = ST_INHIBIT;
          clk_lo_d = 1'b1;
          dat_lo_d = 1'b0;
          cnt_d    = '0;
          bitcnt_d = '0;
          nack_d   = 1'b0;
`ifdef PS2TX_RETRY_EN
          frame_d  = tx_frame(iDATA);
          retry_d  = '0;
`endif
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
          cnt_d    = '0;
          dat_lo_d = 1'b1;
          state_d  = ST_START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_W'(START_CYC - 1)) begin
          cnt_d    = '0;
          clk_lo_d = 1'b0;
          state_d  = ST_XMIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_XMIT, ST_ACK, ST_WAITIDLE: begin
        // Timeout is checked first so it wins over a coincident falling edge.
        if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
          end_txn = 1'b1;
          end_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          case (state_q)
            ST_XMIT: begin
              if (clk_fall) begin
                dat_lo_d = ~shreg_q[0];
                shreg_d  = {1'b0, shreg_q[9:1]};
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == 4'(FRAME_BITS - 2)) state_d = ST_ACK;
              end
            end
            ST_ACK: begin
              if (clk_fall) begin
                nack_d  = dat_line;
                state_d = ST_WAITIDLE;
              end
            end
            default: begin
              if (clk_line && dat_line) begin
                end_txn = 1'b1;
                end_err = nack_q;
              end
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (end_txn) begin
      clk_lo_d = 1'b0;
      dat_lo_d = 1'b0;
      cnt_d    = '0;
      state_d  = ST_IDLE;
      done_c   = 1'b1;
      err_c    = end_err;
`ifdef PS2TX_RETRY_EN
      if (end_err && (retry_q != RW'(RETRY_MAX))) begin
        done_c   = 1'b0;
        err_c    = 1'b0;
        retry_d  = retry_q + 1'b1;
        state_d  = ST_INHIBIT;
        clk_lo_d = 1'b1;
        shreg_d  = frame_q;
        bitcnt_d = '0;
        nack_d   = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge CLK50M or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      clk_lo_q <= 1'b0;
      dat_lo_q <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      clk_lo_q <= clk_lo_d;
      dat_lo_q <= dat_lo_d;
      nack_q   <= nack_d;
    end
  end

`ifdef PS2TX_RETRY_EN
  always_ff @(posedge CLK50M or posedge RESET) begin
    if (RESET) begin
      frame_q <= '0;
      retry_q <= '0;
    end else begin
      frame_q <= frame_d;
      retry_q <= retry_d;
    end
  end
`endif

  assign oPS2CLK_LO = clk_lo_q;
  assign oPS2DAT_LO = dat_lo_q;
  assign oREADY     = (state_q == ST_IDLE);
  assign oBUSY      = (state_q != ST_IDLE);
  assign oDONE      = done_c;
  assign oERR       = err_c;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a behavioural keyboard clocks frames out of
// the DUT over an open-drain pad model and answers ACK, NACK or nothing.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH  = 1000;
  localparam int unsigned STC  = 50;
  localparam int unsigned TO   = 4000;
  localparam int unsigned FILT = 8;
  localparam int unsigned RMAX = 2;
  localparam int unsigned HALF = 40;
  localparam int unsigned WMAX = 3 * TO;
`ifdef PS2TX_RETRY_EN
  localparam int unsigned ATT_ON_ERR = RMAX + 1;
`else
  localparam int unsigned ATT_ON_ERR = 1;
`endif
  localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dev_clk_lo = 1'b0, dev_dat_lo = 1'b0, glitch = 1'b0;
  logic       pad_clk, pad_dat, clk_lo, dat_lo;
  logic [7:0] data = 8'h00;
  logic       req = 1'b0;
  logic       ready, busy, done, err;

  assign pad_clk = ~(clk_lo | dev_clk_lo | glitch);
  assign pad_dat = ~(dat_lo | dev_dat_lo);

  always #10 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYC(INH),
    .START_CYC  (STC),
    .TIMEOUT_CYC(TO),
    .FILT_CYC   (FILT),
    .RETRY_MAX  (RMAX)
  ) dut (
    .CLK50M    (clk),
    .RESET     (rst),
    .iPS2CLK   (pad_clk),
    .iPS2DAT   (pad_dat),
    .oPS2CLK_LO(clk_lo),
    .oPS2DAT_LO(dat_lo),
    .iDATA     (data),
    .iREQ      (req),
    .oREADY    (ready),
    .oBUSY     (busy),
    .oDONE     (done),
    .oERR      (err)
  );

  typedef struct packed {
    logic [10:0] frame;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned rel_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Free-running monitors; the stimulus thread only reads them.
  int unsigned cyc = 0, done_cnt = 0, inh_cnt = 0, done_cyc = 0;
  logic        done_err = 1'b0, prev_clk_lo = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_err <= err;
      done_cyc <= cyc;
    end
    if (clk_lo && !prev_clk_lo) inh_cnt <= inh_cnt + 1;
    prev_clk_lo <= clk_lo;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic dev_attempt(input int mode, input int gbit, input int qbit, input int rbit,
                             output logic [10:0] fr, output bit aborted);
    int unsigned n;
    fr = '0;
    aborted = 1'b0;
    n = 0;
    while (!clk_lo && n < WMAX) begin tick(); n++; end
    chk("inhibit_seen", clk_lo, 1);
    n = 0;
    while (clk_lo && !dat_lo && n < WMAX) begin tick(); n++; end
    chk("inhibit_len", n, INH);
    n = 0;
    while (clk_lo && dat_lo && n < WMAX) begin tick(); n++; end
    chk("start_len", n, STC);
    rel_cyc = cyc;
    if (mode == M_SILENT) return;
    repeat (HALF) tick();
    fr[0] = pad_dat;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_lo = 1'b1;
      if (i == rbit) begin
        repeat (15) tick();
        chk("pre_reset_dat_lo", dat_lo, 1);
        #3 rst = 1'b1;
        #1;
        chk("reset_async_release", {clk_lo, dat_lo}, 2'b00);
        dev_clk_lo = 1'b0;
        aborted = 1'b1;
        return;
      end
      if (i == qbit) begin
        tick();
        req  = 1'b1;
        data = 8'h55;
        chk("req_ignored_ready", {ready, busy}, 2'b01);
        tick();
        req = 1'b0;
        repeat (HALF - 2) tick();
      end else begin
        repeat (HALF) tick();
      end
      fr[i] = pad_dat;
      dev_clk_lo = 1'b0;
      if (i == gbit) begin
        repeat (15) tick();
        glitch = 1'b1;
        repeat (3) tick();
        glitch = 1'b0;
        repeat (HALF - 18) tick();
      end else begin
        repeat (HALF) tick();
      end
    end
    if (mode == M_ACK) dev_dat_lo = 1'b1;
    repeat (HALF) tick();
    dev_clk_lo = 1'b1;
    repeat (HALF) tick();
    dev_clk_lo = 1'b0;
    dev_dat_lo = 1'b0;
  endtask

  task automatic do_txn(input logic [7:0] b, input int mode, input int gbit, input int qbit,
                        input int rbit);
    exp_t        e;
    logic [10:0] fr;
    bit          ab;
    int unsigned d0, i0, n, tries;
    tries = (mode == M_ACK) ? 1 : ATT_ON_ERR;
    d0 = done_cnt;
    i0 = inh_cnt;
    ab = 1'b0;
    fr = '0;
    tick();
    chk("ready_before_req", ready, 1);
    data = b;
    req  = 1'b1;
    e.frame = {1'b1, ~^b, b, 1'b0};
    e.err   = (mode != M_ACK);
    sb_q.push_back(e);
    tick();
    req  = 1'b0;
    data = ~b;
    for (int a = 0; a < int'(tries); a++) begin
      dev_attempt(mode, gbit, qbit, rbit, fr, ab);
      if (ab) break;
    end
    if (ab) begin
      repeat (3) tick();
      rst = 1'b0;
      repeat (30) tick();
      chk("reset_no_done", done_cnt - d0, 0);
      chk("reset_idle", {ready, busy, clk_lo, dat_lo}, 4'b1000);
      e = sb_q.pop_front();
      return;
    end
    n = 0;
    while (done_cnt == d0 && n < WMAX) begin tick(); n++; end
    chk("done_seen", done_cnt != d0, 1);
    e = sb_q.pop_front();
    if (mode != M_SILENT) chk("frame_bits", fr, e.frame);
    else chk("timeout_cycles", done_cyc - rel_cyc, TO);
    chk("done_err", done_err, e.err);
    tick();
    chk("single_done", done_cnt - d0, 1);
    chk("inhibit_phases", inh_cnt - i0, tries);
    chk("ready_after", {ready, busy, clk_lo, dat_lo}, 4'b1000);
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_outputs", {ready, busy, done, err, clk_lo, dat_lo}, 6'b100000);
    rst = 1'b0;
    repeat (20) tick();
    chk("idle_after_reset", {ready, busy, done, err, clk_lo, dat_lo}, 6'b100000);

    do_txn(CMD_SET_LED, M_ACK, 0, 0, 0);
    do_txn(8'h00, M_ACK, 0, 0, 0);
    do_txn(8'h01, M_ACK, 0, 0, 0);
    do_txn(8'h3C, M_NACK, 0, 0, 0);
    do_txn(8'h5A, M_SILENT, 0, 0, 0);
    do_txn(8'hF0, M_ACK, 0, 3, 0);
    do_txn(8'hA5, M_ACK, 0, 0, 5);
    do_txn(CMD_RESET, M_ACK, 0, 0, 0);
    do_txn(CMD_ECHO, M_ACK, 4, 0, 0);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
    $fatal(1);
  end

endmodule
